merge_2: RTL and testbench

MERGE_2 -- requirements
Module: merge_2

---
 rtl/merge_2.sv | 197 +++++++++++++++++++
 tb/tb_merge_2.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/merge_2.sv
// Two-input packet merger: round-robin arbitration at packet boundaries into a
// one-entry output register; stray beats arriving outside a packet are counted and discarded.
module merge_2 #(
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  in_pkt_0_data,
    input  logic               in_pkt_0_valid,
    input  logic               in_pkt_0_sop,
    input  logic               in_pkt_0_eop,
    input  logic [EMPTY_W-1:0] in_pkt_0_empty,
    output logic               in_pkt_0_ready,
    output logic               in_pkt_0_almost_full,
    input  logic [DATA_W-1:0]  in_pkt_1_data,
    input  logic               in_pkt_1_valid,
    input  logic               in_pkt_1_sop,
    input  logic               in_pkt_1_eop,
    input  logic [EMPTY_W-1:0] in_pkt_1_empty,
    output logic               in_pkt_1_ready,
    output logic               in_pkt_1_almost_full,
    output logic [DATA_W-1:0]  out_pkt_data,
    output logic [EMPTY_W-1:0] out_pkt_empty,
    output logic               out_pkt_valid,
    output logic               out_pkt_sop,
    output logic               out_pkt_eop,
    output logic [1:0]         out_pkt_channel,
    input  logic               out_pkt_ready,
    input  logic               out_pkt_almost_full,
    output logic [31:0]        drop_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                rr_last_q, rr_last_d;
    logic                out_valid_q, out_valid_d;
    logic                out_sop_q, out_sop_d;
    logic                out_eop_q, out_eop_d;
    logic [1:0]          out_channel_q, out_channel_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [EMPTY_W-1:0]  out_empty_q, out_empty_d;
    logic [31:0]         drop_cnt_q, drop_cnt_d;

    logic out_free_s;
    logic cand0_s, cand1_s;
    logic grant0_s, grant1_s;
    logic drop0_s, drop1_s;
    logic ready0_s, ready1_s;
    logic acc0_s, acc1_s;

    // Grant, discard and handshake decode for both inputs
    always_comb begin
        out_free_s = !out_valid_q || out_pkt_ready;
        cand0_s    = in_pkt_0_valid & in_pkt_0_sop;
        cand1_s    = in_pkt_1_valid & in_pkt_1_sop;
        grant0_s   = 1'b0;
        grant1_s   = 1'b0;
        drop0_s    = 1'b0;
        drop1_s    = 1'b0;
        case (state_q)
            IDLE: begin
                // rr_last_q == 1 means input 1 went last, so input 0 wins a tie
                if (cand0_s && cand1_s) begin
                    grant0_s = rr_last_q;
                    grant1_s = !rr_last_q;
                end else begin
                    grant0_s = cand0_s;
                    grant1_s = cand1_s;
                end
                drop0_s = in_pkt_0_valid & !in_pkt_0_sop & rst;
                drop1_s = in_pkt_1_valid & !in_pkt_1_sop & rst;
            end
            LOCK0: begin
                grant0_s = 1'b1;
            end
            LOCK1: begin
                grant1_s = 1'b1;
            end
            default: begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        endcase
        ready0_s = rst & ((grant0_s & out_free_s) | drop0_s);
        ready1_s = rst & ((grant1_s & out_free_s) | drop1_s);
        acc0_s   = in_pkt_0_valid & ready0_s & grant0_s;
        acc1_s   = in_pkt_1_valid & ready1_s & grant1_s;
    end

    // Arbiter next-state and round-robin pointer
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        case (state_q)
            IDLE: begin
                if (acc0_s) begin
                    rr_last_d = 1'b0;
                    state_d   = in_pkt_0_eop ? IDLE : LOCK0;
                end else if (acc1_s) begin
                    rr_last_d = 1'b1;
                    state_d   = in_pkt_1_eop ? IDLE : LOCK1;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCK0: begin
                if (acc0_s && in_pkt_0_eop) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCK0;
                end
            end
            LOCK1: begin
                if (acc1_s && in_pkt_1_eop) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCK1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register: load on accept, drain on sink ready, otherwise hold
    always_comb begin
        out_valid_d   = out_valid_q & !out_pkt_ready;
        out_sop_d     = out_sop_q;
        out_eop_d     = out_eop_q;
        out_channel_d = out_channel_q;
        out_data_d    = out_data_q;
        out_empty_d   = out_empty_q;
        if (acc0_s) begin
            out_valid_d   = 1'b1;
            out_sop_d     = in_pkt_0_sop;
            out_eop_d     = in_pkt_0_eop;
            out_channel_d = 2'd0;
            out_data_d    = in_pkt_0_data;
            out_empty_d   = in_pkt_0_empty;
        end else if (acc1_s) begin
            out_valid_d   = 1'b1;
            out_sop_d     = in_pkt_1_sop;
            out_eop_d     = in_pkt_1_eop;
            out_channel_d = 2'd1;
            out_data_d    = in_pkt_1_data;
            out_empty_d   = in_pkt_1_empty;
        end else begin
            out_channel_d = out_channel_q;
        end
        drop_cnt_d = drop_cnt_q + {31'd0, drop0_s} + {31'd0, drop1_s};
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            rr_last_q     <= 1'b1;
            out_valid_q   <= 1'b0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            out_channel_q <= 2'd0;
            out_data_q    <= {DATA_W{1'b0}};
            out_empty_q   <= {EMPTY_W{1'b0}};
            drop_cnt_q    <= 32'd0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            out_valid_q   <= out_valid_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            out_channel_q <= out_channel_d;
            out_data_q    <= out_data_d;
            out_empty_q   <= out_empty_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign in_pkt_0_ready       = ready0_s;
    assign in_pkt_1_ready       = ready1_s;
    assign in_pkt_0_almost_full = out_pkt_almost_full;
    assign in_pkt_1_almost_full = out_pkt_almost_full;
    assign out_pkt_valid        = out_valid_q;
    assign out_pkt_sop          = out_sop_q;
    assign out_pkt_eop          = out_eop_q;
    assign out_pkt_channel      = out_channel_q;
    assign out_pkt_data         = out_data_q;
    assign out_pkt_empty        = out_empty_q;
    assign drop_cnt             = drop_cnt_q;

endmodule

// File: tb/tb_merge_2.sv
// Bench for merge_2: directed scenarios plus randomized packet traffic checked
// against per-channel packet queues and a drop counter model.
module tb_merge_2;
    localparam int DW = 512;
    localparam int EW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_pkt_0_data, in_pkt_1_data;
    logic          in_pkt_0_valid, in_pkt_0_sop, in_pkt_0_eop, in_pkt_0_ready, in_pkt_0_almost_full;
    logic          in_pkt_1_valid, in_pkt_1_sop, in_pkt_1_eop, in_pkt_1_ready, in_pkt_1_almost_full;
    logic [EW-1:0] in_pkt_0_empty, in_pkt_1_empty;
    logic [DW-1:0] out_pkt_data;
    logic [EW-1:0] out_pkt_empty;
    logic          out_pkt_valid, out_pkt_sop, out_pkt_eop, out_pkt_ready, out_pkt_almost_full;
    logic [1:0]    out_pkt_channel;
    logic [31:0]   drop_cnt;

    always #5 clk = ~clk;

    merge_2 #(.DATA_W(DW), .EMPTY_W(EW)) dut (
        .clk(clk), .rst(rst),
        .in_pkt_0_data(in_pkt_0_data), .in_pkt_0_valid(in_pkt_0_valid), .in_pkt_0_sop(in_pkt_0_sop),
        .in_pkt_0_eop(in_pkt_0_eop), .in_pkt_0_empty(in_pkt_0_empty), .in_pkt_0_ready(in_pkt_0_ready),
        .in_pkt_0_almost_full(in_pkt_0_almost_full),
        .in_pkt_1_data(in_pkt_1_data), .in_pkt_1_valid(in_pkt_1_valid), .in_pkt_1_sop(in_pkt_1_sop),
        .in_pkt_1_eop(in_pkt_1_eop), .in_pkt_1_empty(in_pkt_1_empty), .in_pkt_1_ready(in_pkt_1_ready),
        .in_pkt_1_almost_full(in_pkt_1_almost_full),
        .out_pkt_data(out_pkt_data), .out_pkt_empty(out_pkt_empty), .out_pkt_valid(out_pkt_valid),
        .out_pkt_sop(out_pkt_sop), .out_pkt_eop(out_pkt_eop), .out_pkt_channel(out_pkt_channel),
        .out_pkt_ready(out_pkt_ready), .out_pkt_almost_full(out_pkt_almost_full),
        .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [EW-1:0] empty;
        logic          sop;
        logic          eop;
    } beat_t;

    beat_t       src0[$], src1[$], exp0[$], exp1[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          vpct = 100;
    int          rpct = 100;
    bit          chk_stall = 1'b1;
    int          tick_no = 0;
    bit          log_en = 1'b0;
    int          log_cyc[$];
    int          log_ch[$];
    bit          open_pkt = 1'b0;
    logic [1:0]  open_ch = 2'd0;
    logic [31:0] exp_drop = 32'd0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic push_pkt(input int k, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data  = rand_data();
            b.sop   = (i == 0);
            b.eop   = (i == len - 1);
            b.empty = (i == len - 1) ? EW'($urandom_range(63)) : 6'd0;
            if (k == 0) begin src0.push_back(b); exp0.push_back(b); end
            else begin src1.push_back(b); exp1.push_back(b); end
        end
    endtask

    task automatic push_stray(input int k, input bit eop);
        beat_t b;
        b.data = rand_data(); b.sop = 1'b0; b.eop = eop; b.empty = 6'd0;
        if (k == 0) src0.push_back(b); else src1.push_back(b);
        exp_drop = exp_drop + 32'd1;
    endtask

    task automatic check_out(input beat_t b, input logic [1:0] ch);
        beat_t e;
        bit    has_exp;
        if (log_en) begin log_cyc.push_back(tick_no); log_ch.push_back(int'(ch)); end
        has_exp = 1'b0;
        if (ch == 2'd0 && exp0.size() > 0) begin e = exp0.pop_front(); has_exp = 1'b1; end
        else if (ch == 2'd1 && exp1.size() > 0) begin e = exp1.pop_front(); has_exp = 1'b1; end
        else has_exp = 1'b0;
        check("out_beat_expected", has_exp, 1'b1);
        if (has_exp) begin
            check("out_data", b.data, e.data);
            check("out_empty", b.empty, e.empty);
            check("out_sop", b.sop, e.sop);
            check("out_eop", b.eop, e.eop);
        end
        if (open_pkt) check("no_interleave", ch, open_ch);
        open_pkt = !b.eop;
        open_ch  = ch;
    endtask

    // One clock cycle, entered and left at the falling edge
    task automatic tick();
        beat_t      sb;
        logic       sv, sr, acc0, acc1;
        logic [1:0] sch;
        if (!in_pkt_0_valid) begin
            if (src0.size() > 0 && $urandom_range(99) < vpct) begin
                in_pkt_0_valid = 1'b1; in_pkt_0_data = src0[0].data; in_pkt_0_empty = src0[0].empty;
                in_pkt_0_sop = src0[0].sop; in_pkt_0_eop = src0[0].eop;
            end else in_pkt_0_valid = 1'b0;
        end
        if (!in_pkt_1_valid) begin
            if (src1.size() > 0 && $urandom_range(99) < vpct) begin
                in_pkt_1_valid = 1'b1; in_pkt_1_data = src1[0].data; in_pkt_1_empty = src1[0].empty;
                in_pkt_1_sop = src1[0].sop; in_pkt_1_eop = src1[0].eop;
            end else in_pkt_1_valid = 1'b0;
        end
        out_pkt_ready = ($urandom_range(99) < rpct);
        #1;
        acc0 = in_pkt_0_valid & in_pkt_0_ready;
        acc1 = in_pkt_1_valid & in_pkt_1_ready;
        if (chk_stall && out_pkt_valid && !out_pkt_ready) begin
            check("stall_ready0", in_pkt_0_ready, 1'b0);
            check("stall_ready1", in_pkt_1_ready, 1'b0);
        end
        sv = out_pkt_valid; sr = out_pkt_ready; sch = out_pkt_channel;
        sb.data = out_pkt_data; sb.empty = out_pkt_empty; sb.sop = out_pkt_sop; sb.eop = out_pkt_eop;
        if (sv && sr) check_out(sb, sch);
        @(posedge clk);
        @(negedge clk);
        if (acc0) begin void'(src0.pop_front()); in_pkt_0_valid = 1'b0; end
        if (acc1) begin void'(src1.pop_front()); in_pkt_1_valid = 1'b0; end
        if (sv && !sr) begin
            check("hold_valid", out_pkt_valid, 1'b1);
            check("hold_data", out_pkt_data, sb.data);
            check("hold_empty", out_pkt_empty, sb.empty);
            check("hold_sop_eop", {out_pkt_sop, out_pkt_eop}, {sb.sop, sb.eop});
            check("hold_channel", out_pkt_channel, sch);
        end
        tick_no++;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while ((src0.size() + src1.size() + exp0.size() + exp1.size() > 0 ||
                in_pkt_0_valid || in_pkt_1_valid || out_pkt_valid) && guard < 3000) begin
            tick();
            guard++;
        end
        check({tag, "_timeout"}, guard < 3000, 1'b1);
    endtask

    initial begin
        int base;
        beat_t b1;
        rst = 1'b0;
        in_pkt_0_valid = 1'b0; in_pkt_0_sop = 1'b0; in_pkt_0_eop = 1'b0; in_pkt_0_data = '0; in_pkt_0_empty = 6'd0;
        in_pkt_1_valid = 1'b0; in_pkt_1_sop = 1'b0; in_pkt_1_eop = 1'b0; in_pkt_1_data = '0; in_pkt_1_empty = 6'd0;
        out_pkt_ready = 1'b0; out_pkt_almost_full = 1'b0;
        #2;
        in_pkt_0_valid = 1'b1;
        in_pkt_1_valid = 1'b1;
        #1;
        check("rst_ready0", in_pkt_0_ready, 1'b0);
        check("rst_ready1", in_pkt_1_ready, 1'b0);
        check("rst_out_valid", out_pkt_valid, 1'b0);
        check("rst_out_flags", {out_pkt_sop, out_pkt_eop, out_pkt_channel}, 4'd0);
        check("rst_out_data", out_pkt_data, '0);
        check("rst_out_empty", out_pkt_empty, 6'd0);
        check("rst_drop_cnt", drop_cnt, 32'd0);
        in_pkt_0_valid = 1'b0;
        in_pkt_1_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        out_pkt_almost_full = 1'b1; #1;
        check("afull_hi", {in_pkt_0_almost_full, in_pkt_1_almost_full}, 2'b11);
        out_pkt_almost_full = 1'b0; #1;
        check("afull_lo", {in_pkt_0_almost_full, in_pkt_1_almost_full}, 2'b00);
        @(negedge clk);

        // Two 3-beat packets presented together
        log_en = 1'b1; log_cyc.delete(); log_ch.delete();
        push_pkt(0, 3); push_pkt(1, 3);
        base = tick_no;
        drain("two_pkts");
        check("two_pkts_count", log_ch.size(), 6);
        for (int i = 0; i < 6 && i < log_ch.size(); i++) begin
            check("two_pkts_cycle", log_cyc[i], base + i + 1);
            check("two_pkts_chan", log_ch[i], (i < 3) ? 0 : 1);
        end

        // Continuous single-beat packets on both inputs
        log_cyc.delete(); log_ch.delete();
        for (int i = 0; i < 8; i++) begin push_pkt(0, 1); push_pkt(1, 1); end
        base = tick_no;
        drain("single_beats");
        check("single_beats_count", log_ch.size(), 16);
        for (int i = 0; i < 16 && i < log_ch.size(); i++) begin
            check("single_beats_cycle", log_cyc[i], base + i + 1);
            check("single_beats_chan", log_ch[i], i % 2);
        end

        // Sink stalls for 5 cycles in the middle of a packet
        push_pkt(0, 6);
        rpct = 100; for (int i = 0; i < 3; i++) tick();
        rpct = 0;   for (int i = 0; i < 5; i++) tick();
        rpct = 100;
        drain("stall");

        // Stray beats on input 1 while idle
        chk_stall = 1'b0;
        log_cyc.delete(); log_ch.delete();
        exp_drop = 32'd0;
        push_stray(1, 1'b0); push_stray(1, 1'b1);
        drain("stray");
        check("stray_no_output", log_ch.size(), 0);
        check("stray_drop_cnt", drop_cnt, exp_drop);

        // Reset in the middle of a 4-beat packet on input 0
        b1.data = rand_data();
        in_pkt_0_valid = 1'b1; in_pkt_0_sop = 1'b1; in_pkt_0_eop = 1'b0; in_pkt_0_data = b1.data; in_pkt_0_empty = 6'd0;
        out_pkt_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("mid_rst_beat1_valid", out_pkt_valid, 1'b1);
        check("mid_rst_beat1_data", out_pkt_data, b1.data);
        in_pkt_0_sop = 1'b0; in_pkt_0_data = rand_data();
        #2 rst = 1'b0;
        #1;
        check("mid_rst_out_valid", out_pkt_valid, 1'b0);
        check("mid_rst_out_data", out_pkt_data, '0);
        check("mid_rst_ready0", in_pkt_0_ready, 1'b0);
        check("mid_rst_drop_cnt", drop_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        in_pkt_0_valid = 1'b0;
        exp_drop = 32'd0;
        open_pkt = 1'b0;
        push_stray(0, 1'b0); push_stray(0, 1'b1);
        drain("post_rst_stray");
        check("post_rst_drop_cnt", drop_cnt, exp_drop);
        log_cyc.delete(); log_ch.delete();
        push_pkt(1, 2);
        drain("post_rst_pkt");
        check("post_rst_pkt_count", log_ch.size(), 2);
        for (int i = 0; i < log_ch.size(); i++) check("post_rst_pkt_chan", log_ch[i], 1);
        log_en = 1'b0;
        chk_stall = 1'b1;

        // Randomized well-formed traffic with random valid gaps and sink backpressure
        for (int r = 0; r < 4; r++) begin
            vpct = $urandom_range(100, 40);
            rpct = $urandom_range(100, 30);
            out_pkt_almost_full = $urandom_range(1);
            for (int p = 0; p < 12; p++) begin
                push_pkt(0, $urandom_range(5, 1));
                push_pkt(1, $urandom_range(5, 1));
            end
            drain("random");
        end
        check("random_drop_cnt", drop_cnt, exp_drop);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
